// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared register map, bit indices and FSM encodings for uart_ctrl
package uart_pkg;

    localparam int OVS = 16;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_RXDATA = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int ST_RX_EMPTY   = 0;
    localparam int ST_RX_FULL    = 1;
    localparam int ST_TX_EMPTY   = 2;
    localparam int ST_TX_FULL    = 3;
    localparam int ST_TX_BUSY    = 4;
    localparam int ST_PARITY_ERR = 5;
    localparam int ST_FRAME_ERR  = 6;
    localparam int ST_RX_OVF     = 7;
    localparam int ST_TX_OVF     = 8;

    localparam int CT_PAR_EN   = 16;
    localparam int CT_PAR_ODD  = 17;
    localparam int CT_TWO_STOP = 18;
    localparam int CT_RX_IE    = 19;
    localparam int CT_TX_IE    = 20;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP, TX_STOP2
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
    } rx_state_t;

endpackage

// File: rtl/uart_sfifo.sv
// rtl/uart_sfifo.sv - single-clock FIFO with extra-bit pointers and first-word-fall-through read
module uart_sfifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_pop;
    logic             do_push;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    // A pop on a full FIFO frees the slot the simultaneous push needs.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr[AW-1:0]];

    // Pointer advance; the top pointer bit distinguishes full from empty.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge i_clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_ctrl.sv
// rtl/uart_ctrl.sv - Wishbone UART with 16x oversampling, parity, FIFOs, sticky errors and irq
module uart_ctrl
    import uart_pkg::*;
#(
    parameter int          DATA_BITS = 8,
    parameter int          TX_DEPTH  = 16,
    parameter int          RX_DEPTH  = 16,
    parameter logic [15:0] DIV_RESET = 16'd26
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [3:0]  i_wb_addr,
    input  logic [31:0] i_wb_data,
    output logic [31:0] o_wb_data,
    output logic        o_wb_ack,
    input  logic        i_rx,
    output logic        o_tx,
    output logic        o_irq
);
    logic [20:0] ctrl_q;
    logic [3:0]  sticky;
    logic [15:0] baud_cnt;
    logic        tick;
    logic        req, wr, rd, tx_push, rx_pop, ctrl_we;
    logic [1:0]  sel;
    logic [3:0]  w1c, sticky_set;
    logic [31:0] rdata_mux;
    logic        tx_full, tx_empty, tx_pop, tx_busy;
    logic        rx_full, rx_empty, rx_push;
    logic [DATA_BITS-1:0] tx_dout, rx_dout;
    logic        unused_bits;

    tx_state_t   tx_state, tx_next;
    logic [3:0]  tx_ovs;
    logic [2:0]  tx_bit;
    logic [DATA_BITS-1:0] tx_shift;
    logic        tx_par, tx_fmt_par, tx_fmt_two;
    logic        tx_bit_done;

    rx_state_t   rx_state, rx_next;
    logic        rx_s1, rx_s2, rx_d, rx_fall, rx_sample, rx_ferr;
    logic [3:0]  rx_ovs;
    logic [2:0]  rx_bit;
    logic [DATA_BITS-1:0] rx_shift;
    logic        rx_par_bad;

    assign unused_bits = ^{i_wb_addr[1:0], i_wb_data[31:21]};

    assign req     = i_wb_cyc && i_wb_stb && !o_wb_ack;
    assign wr      = req && i_wb_we;
    assign rd      = req && !i_wb_we;
    assign sel     = i_wb_addr[3:2];
    assign tx_push = wr && (sel == REG_TXDATA);
    assign rx_pop  = rd && (sel == REG_RXDATA);
    assign ctrl_we = wr && (sel == REG_CTRL);
    assign w1c     = (wr && (sel == REG_STATUS)) ? i_wb_data[ST_TX_OVF:ST_PARITY_ERR] : 4'b0;
    assign tx_busy = (tx_state != TX_IDLE);

    // Sticky sources, ordered as STATUS[8:5]: parity, frame, rx overflow, tx overflow.
    assign sticky_set = {tx_push && tx_full && !tx_pop,
                         rx_push && rx_full && !rx_pop,
                         rx_ferr,
                         rx_push && rx_par_bad};

    uart_sfifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .i_clk(i_clk), .i_rstn(i_rstn), .push(tx_push), .pop(tx_pop),
        .din(i_wb_data[DATA_BITS-1:0]), .dout(tx_dout), .full(tx_full), .empty(tx_empty)
    );

    uart_sfifo #(.WIDTH(DATA_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .i_clk(i_clk), .i_rstn(i_rstn), .push(rx_push), .pop(rx_pop),
        .din(rx_shift), .dout(rx_dout), .full(rx_full), .empty(rx_empty)
    );

    // Register read selection; an empty RX FIFO reads as zero.
    always_comb begin
        rdata_mux = 32'd0;
        case (sel)
            REG_RXDATA: rdata_mux = rx_empty ? 32'd0 : 32'(rx_dout);
            REG_STATUS: rdata_mux = {23'd0, sticky, tx_busy, tx_full, tx_empty, rx_full, rx_empty};
            REG_CTRL:   rdata_mux = {11'd0, ctrl_q};
            default:    rdata_mux = 32'd0;
        endcase
    end

    // Bus handshake, control/sticky registers and the registered interrupt.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_wb_ack  <= 1'b0;
            o_wb_data <= 32'd0;
            ctrl_q    <= {5'd0, DIV_RESET};
            sticky    <= 4'd0;
            o_irq     <= 1'b0;
        end else begin
            o_wb_ack <= i_wb_cyc && i_wb_stb && !o_wb_ack;
            if (req) o_wb_data <= i_wb_we ? 32'd0 : rdata_mux;
            if (ctrl_we) ctrl_q <= i_wb_data[20:0];
            sticky <= (sticky & ~w1c) | sticky_set;
            o_irq  <= (ctrl_q[CT_RX_IE] && !rx_empty) ||
                      (ctrl_q[CT_TX_IE] && tx_empty && !tx_busy);
        end
    end

    // Baud tick: period div+1, a new divisor takes effect at the next reload.
    assign tick = (baud_cnt == 16'd0);
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)   baud_cnt <= DIV_RESET;
        else if (tick) baud_cnt <= ctrl_q[15:0];
        else           baud_cnt <= baud_cnt - 16'd1;
    end

    // TX line is decoded from registered state so reset forces it high at once.
    always_comb begin
        case (tx_state)
            TX_START:  o_tx = 1'b0;
            TX_DATA:   o_tx = tx_shift[0];
            TX_PARITY: o_tx = tx_par;
            default:   o_tx = 1'b1;
        endcase
    end

    // TX next state; leaving IDLE pops the FIFO.
    always_comb begin
        tx_next     = tx_state;
        tx_pop      = 1'b0;
        tx_bit_done = tick && (tx_ovs == 4'(OVS - 1));
        case (tx_state)
            TX_IDLE:   if (tick && !tx_empty) begin
                           tx_pop  = 1'b1;
                           tx_next = TX_START;
                       end
            TX_START:  if (tx_bit_done) tx_next = TX_DATA;
            TX_DATA:   if (tx_bit_done && tx_bit == 3'(DATA_BITS - 1))
                           tx_next = tx_fmt_par ? TX_PARITY : TX_STOP;
            TX_PARITY: if (tx_bit_done) tx_next = TX_STOP;
            TX_STOP:   if (tx_bit_done) tx_next = tx_fmt_two ? TX_STOP2 : TX_IDLE;
            TX_STOP2:  if (tx_bit_done) tx_next = TX_IDLE;
            default:   tx_next = TX_IDLE;
        endcase
    end

    // TX state and datapath; frame format is frozen at the pop.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            tx_state   <= TX_IDLE;
            tx_ovs     <= 4'd0;
            tx_bit     <= 3'd0;
            tx_shift   <= '0;
            tx_par     <= 1'b0;
            tx_fmt_par <= 1'b0;
            tx_fmt_two <= 1'b0;
        end else begin
            tx_state <= tx_next;
            if (tx_pop) begin
                tx_shift   <= tx_dout;
                tx_par     <= (^tx_dout) ^ ctrl_q[CT_PAR_ODD];
                tx_fmt_par <= ctrl_q[CT_PAR_EN];
                tx_fmt_two <= ctrl_q[CT_TWO_STOP];
                tx_ovs     <= 4'd0;
                tx_bit     <= 3'd0;
            end else if (tick && tx_busy) begin
                tx_ovs <= tx_ovs + 4'd1;
                if (tx_bit_done && tx_state == TX_DATA) begin
                    tx_shift <= tx_shift >> 1;
                    tx_bit   <= tx_bit + 3'd1;
                end
            end
        end
    end

    // Two-flop synchroniser plus a delayed copy for falling-edge detection.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= i_rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    // Start bit is sampled 8 ticks after the edge, later bits every 16 ticks.
    assign rx_fall   = rx_d && !rx_s2;
    assign rx_sample = tick && ((rx_state == RX_START) ? (rx_ovs == 4'(OVS/2 - 1))
                                                       : (rx_ovs == 4'(OVS - 1)));

    // RX next state, push and frame-error decisions.
    always_comb begin
        rx_next = rx_state;
        rx_push = 1'b0;
        rx_ferr = 1'b0;
        case (rx_state)
            RX_IDLE:      if (rx_fall) rx_next = RX_START;
            RX_START:     if (rx_sample) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:      if (rx_sample && rx_bit == 3'(DATA_BITS - 1))
                              rx_next = ctrl_q[CT_PAR_EN] ? RX_PARITY : RX_STOP;
            RX_PARITY:    if (rx_sample) rx_next = RX_STOP;
            RX_STOP:      if (rx_sample) begin
                              if (rx_s2) begin
                                  rx_push = 1'b1;
                                  rx_next = RX_IDLE;
                              end else begin
                                  rx_ferr = 1'b1;
                                  rx_next = RX_WAIT_HIGH;
                              end
                          end
            RX_WAIT_HIGH: if (rx_s2) rx_next = RX_IDLE;
            default:      rx_next = RX_IDLE;
        endcase
    end

    // RX state and datapath; counters idle at zero until a start edge.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rx_state   <= RX_IDLE;
            rx_ovs     <= 4'd0;
            rx_bit     <= 3'd0;
            rx_shift   <= '0;
            rx_par_bad <= 1'b0;
        end else begin
            rx_state <= rx_next;
            if (rx_state == RX_IDLE) begin
                rx_ovs     <= 4'd0;
                rx_bit     <= 3'd0;
                rx_par_bad <= 1'b0;
            end else if (tick) begin
                rx_ovs <= (rx_state == RX_START && rx_sample) ? 4'd0 : rx_ovs + 4'd1;
                if (rx_sample && rx_state == RX_DATA) begin
                    rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
                    rx_bit   <= rx_bit + 3'd1;
                end
                if (rx_sample && rx_state == RX_PARITY)
                    rx_par_bad <= rx_s2 != ((^rx_shift) ^ ctrl_q[CT_PAR_ODD]);
            end
        end
    end

endmodule
